// File: rtl/fetch_unit_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_buf
// Description : Pipelined instruction fetch with in-order instruction buffer,
//               up to MAX_OUTST IMEM requests in flight, and redirect/flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit_buf #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            proc_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_rdy,
  input  logic            mem_valid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  output logic            stall
);

  localparam int c_cnt_w = $clog2(MAX_OUTST + 1);
  localparam int c_lvl_w = $clog2(DEPTH + 1);
  localparam int c_sum_w = c_lvl_w + 1;
  localparam int c_aw    = $clog2(DEPTH);
  localparam int c_qw    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  logic [XLEN-1:0]    r_pc;
  logic [c_cnt_w-1:0] r_outst;
  logic [c_cnt_w-1:0] r_drop;
  logic [c_lvl_w-1:0] r_count;
  logic [c_aw-1:0]    r_wp;
  logic [c_aw-1:0]    r_rp;
  logic [c_qw-1:0]    r_qwp;
  logic [c_qw-1:0]    r_qrp;
  logic [XLEN-1:0]    r_data [DEPTH];
  logic [XLEN-1:0]    r_ipc  [DEPTH];
  logic [XLEN-1:0]    r_pq   [MAX_OUTST];

  logic [c_sum_w-1:0] w_sum_od;
  logic [c_sum_w-1:0] w_sum_oc;
  logic [c_sum_w-1:0] w_drop_redir;
  logic               w_issue;
  logic               w_live;
  logic               w_drop_hit;
  logic               w_push;
  logic               w_pop;

  function automatic logic [c_qw-1:0] q_inc(input logic [c_qw-1:0] p);
    return (p == c_qw'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_sum_od = c_sum_w'(r_outst) + c_sum_w'(r_drop);
  assign w_sum_oc = c_sum_w'(r_outst) + c_sum_w'(r_count);

  // Buffer space is reserved at issue time, so live responses always fit.
  assign proc_req = rst && !redirect &&
                    (w_sum_od < c_sum_w'(MAX_OUTST)) &&
                    (w_sum_oc < c_sum_w'(DEPTH));
  assign mem_addr = r_pc;

  assign w_issue    = proc_req && mem_rdy;
  assign w_drop_hit = mem_valid && (r_drop != '0);
  assign w_live     = mem_valid && (r_drop == '0) && (r_outst != '0);
  assign w_push     = w_live && !redirect;
  assign w_pop      = instr_valid && instr_ready && !redirect;

  // Every request still in flight at a redirect becomes stale; a beat arriving
  // in the redirect cycle retires one of them.
  assign w_drop_redir = w_sum_od - c_sum_w'(mem_valid && (w_sum_od != '0));

  assign instr_valid = (r_count != '0);
  assign stall       = !instr_valid;
  assign instr       = instr_valid ? r_data[r_rp] : '0;
  assign instr_pc    = instr_valid ? r_ipc[r_rp]  : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= RESET_PC;
      r_outst <= '0;
      r_drop  <= '0;
      r_count <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_qwp   <= '0;
      r_qrp   <= '0;
    end else if (redirect) begin
      r_pc    <= redirect_pc;
      r_outst <= '0;
      r_drop  <= c_cnt_w'(w_drop_redir);
      r_count <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_qwp   <= '0;
      r_qrp   <= '0;
    end else begin
      if (w_issue) begin
        r_pc  <= r_pc + XLEN'(4);
        r_qwp <= q_inc(r_qwp);
      end
      if (w_push) begin
        r_wp  <= r_wp + 1'b1;
        r_qrp <= q_inc(r_qrp);
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      if (w_drop_hit) begin
        r_drop <= r_drop - 1'b1;
      end
      r_count <= r_count + c_lvl_w'(w_push) - c_lvl_w'(w_pop);
      r_outst <= r_outst + c_cnt_w'(w_issue) - c_cnt_w'(w_live);
    end
  end

  // Payload storage needs no reset: validity is carried by the counters.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_pq[r_qwp] <= r_pc;
    end
    if (w_push) begin
      r_data[r_wp] <= mem_rdata;
      r_ipc[r_wp]  <= r_pq[r_qrp];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit_buf.sv
`default_nettype none
// Testbench for fetch_unit_buf: IMEM model with configurable latency, in-order
// scoreboard of expected {pc, instr}, phase table plus redirect corner cases.
module tb_fetch_unit_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        proc_req;
  logic [31:0] mem_addr;
  logic        mem_rdy;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        stall;

  fetch_unit_buf #(
    .XLEN(32), .DEPTH(4), .MAX_OUTST(2), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .proc_req(proc_req), .mem_addr(mem_addr), .mem_rdy(mem_rdy),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] start_pc;
    bit          rdy;
    bit          ird;
    int          lat;
    int          cycles;
    int          exp_acc;
  } vec_t;

  exp_t        sb[$];
  logic [31:0] addr_q[$];
  int          due_q[$];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          nacc = 0;
  int          first_iv = 0;
  bit          g_rdy, g_ird;
  int          g_lat;
  logic [31:0] model_pc;
  logic        obs_req, obs_iv, obs_mv;
  logic [31:0] obs_addr;

  function automatic logic [31:0] fdat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a falling edge: drive one cycle, observe, advance to next fall.
  task automatic tick(input bit redir, input logic [31:0] rpc);
    exp_t e;
    cyc++;
    redirect    = redir;
    redirect_pc = rpc;
    mem_rdy     = g_rdy;
    instr_ready = g_ird;
    if (addr_q.size() > 0 && due_q[0] <= cyc) begin
      mem_valid = 1'b1;
      mem_rdata = fdat(addr_q[0]);
      void'(addr_q.pop_front());
      void'(due_q.pop_front());
    end else begin
      mem_valid = 1'b0;
      mem_rdata = $urandom;
    end
    #1;
    obs_req  = proc_req;
    obs_addr = mem_addr;
    obs_iv   = instr_valid;
    obs_mv   = mem_valid;
    check("stall", 32'(stall), 32'(!instr_valid));
    if (instr_valid && first_iv == 0) first_iv = cyc;
    if (redir) begin
      check("redir_noreq", 32'(proc_req), 32'd0);
      sb.delete();
      model_pc = rpc;
    end else begin
      if (proc_req) check("mem_addr", mem_addr, model_pc);
      if (proc_req && mem_rdy) begin
        e.pc   = model_pc;
        e.data = fdat(model_pc);
        sb.push_back(e);
        addr_q.push_back(mem_addr);
        due_q.push_back(cyc + g_lat);
        model_pc = model_pc + 32'd4;
        nacc++;
      end
      if (instr_valid && instr_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected: got pc %h expected none (cycle %0d)", instr_pc, cyc);
        end else begin
          e = sb.pop_front();
          check("instr_pc", instr_pc, e.pc);
          check("instr", instr, e.data);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    g_rdy = 1'b0;
    g_ird = 1'b1;
    repeat (8) tick(1'b0, 32'h0);
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    vec_t tbl[5];
    tbl[0] = '{32'h0000_1000, 1'b1, 1'b1, 1, 10, 10};  // full-rate streaming
    tbl[1] = '{32'h0000_2000, 1'b1, 1'b0, 1, 12, 4};   // decode stalled, buffer fills
    tbl[2] = '{32'h0000_3000, 1'b0, 1'b1, 1, 5,  0};   // IMEM not ready
    tbl[3] = '{32'h0000_4000, 1'b1, 1'b1, 3, 12, 6};   // in-flight limit binds
    tbl[4] = '{32'hFFFF_FFF8, 1'b1, 1'b1, 1, 4,  4};   // PC wraps

    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; mem_rdy = 1'b1;
    mem_valid = 1'b0; mem_rdata = '0; instr_ready = 1'b1;
    model_pc = 32'h0;
    #2 rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_proc_req", 32'(proc_req), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_stall", 32'(stall), 32'd1);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    g_rdy = 1'b1; g_ird = 1'b1; g_lat = 1;
    tick(1'b0, 32'h0);
    check("first_req", 32'(obs_req), 32'd1);
    check("first_addr", obs_addr, 32'h0);
    repeat (7) tick(1'b0, 32'h0);
    check("first_valid_cycle", 32'(first_iv), 32'd3);

    for (int i = 0; i < 5; i++) begin
      drain();
      g_rdy = tbl[i].rdy;
      g_ird = tbl[i].ird;
      g_lat = tbl[i].lat;
      tick(1'b1, tbl[i].start_pc);
      nacc = 0;
      repeat (tbl[i].cycles) tick(1'b0, 32'h0);
      check("accepts", 32'(nacc), 32'(tbl[i].exp_acc));
    end

    // Two requests in flight when redirected: both responses must be dropped.
    drain();
    g_rdy = 1'b1; g_ird = 1'b1; g_lat = 3;
    tick(1'b1, 32'h0);
    tick(1'b0, 32'h0);
    tick(1'b0, 32'h0);
    tick(1'b1, 32'h100);
    tick(1'b0, 32'h0);
    check("drop_block_req", 32'(obs_req), 32'd0);
    tick(1'b0, 32'h0);
    check("redir_req", 32'(obs_req), 32'd1);
    check("redir_addr", obs_addr, 32'h100);
    repeat (6) tick(1'b0, 32'h0);

    // Redirect coinciding with a response beat and a pop.
    drain();
    g_rdy = 1'b1; g_ird = 1'b1; g_lat = 1;
    tick(1'b1, 32'h0);
    repeat (4) tick(1'b0, 32'h0);
    tick(1'b1, 32'h200);
    check("coinc_mem_valid", 32'(obs_mv), 32'd1);
    check("coinc_instr_valid", 32'(obs_iv), 32'd1);
    tick(1'b0, 32'h0);
    check("post_redir_empty", 32'(obs_iv), 32'd0);
    check("post_redir_req", 32'(obs_req), 32'd1);
    check("post_redir_addr", obs_addr, 32'h200);
    repeat (6) tick(1'b0, 32'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit_buf.md
# fetch_unit_buf

Parametrised instruction-fetch unit that owns the program counter, issues pipelined read requests to IMEM over the req/rdy/valid protocol, and buffers returned instructions in an in-order FIFO for decode. Unlike the single-request fetcher, it keeps up to MAX_OUTST requests in flight, supports a PC redirect/flush that discards stale responses, and applies ready/valid backpressure toward decode. It sits between IMEM and the decode stage.

## Interface
- XLEN, 32, address/instruction width
- DEPTH, 4, instruction buffer entries (power of 2, ≥2)
- MAX_OUTST, 2, max in-flight IMEM requests (1..DEPTH)
- RESET_PC, 0, PC value after reset
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- redirect  in  1  load redirect_pc, flush buffer and in-flight responses
- redirect_pc  in  XLEN  new fetch address (word aligned)
- proc_req  out  1  request to IMEM
- mem_addr  out  XLEN  request address (current PC)
- mem_rdy  in  1  IMEM accepts request when proc_req && mem_rdy
- mem_valid  in  1  response beat valid (in order, one per accepted request)
- mem_rdata  in  XLEN  response instruction
- instr_valid  out  1  buffer head valid
- instr  out  XLEN  head instruction
- instr_pc  out  XLEN  PC of head instruction
- instr_ready  in  1  decode consumes head when instr_valid && instr_ready
- stall  out  1  = !instr_valid

## Operation
- State: pc (XLEN), pc_req FIFO of request PCs (MAX_OUTST), instruction FIFO (DEPTH, data+pc), outst and drop counters, width clog2(MAX_OUTST+1), count width clog2(DEPTH+1).
- Issue: proc_req = rst && !redirect && (outst+drop < MAX_OUTST) && (outst+count < DEPTH); mem_addr = pc. On accept: pc <= pc+4 (mod 2^XLEN, wraps silently), push pc into pc_req FIFO, outst+1.
- Response: mem_valid with drop>0 -> discard, drop-1. Else with outst>0 -> push {mem_rdata, pc_req head} into buffer, outst-1. mem_valid with outst=drop=0 -> ignored.
- Buffer space reserved at issue, so a live response never finds buffer full.
- Pop: instr_valid && instr_ready -> head advances, count-1. Push and pop same cycle allowed at any occupancy.
- Redirect (priority over everything): pc <= redirect_pc; count <= 0; pc_req FIFO cleared; drop <= drop + outst - mem_valid; outst <= 0. Pop and any response in that cycle are discarded. No request issued in the redirect cycle.
- Back-to-back redirects accumulate drop correctly; drop never exceeds MAX_OUTST.

## Timing
- Reset (async, rst low): pc=RESET_PC, outst=drop=count=0, proc_req=0, instr_valid=0, stall=1, instr/instr_pc=0. First cycle after release: proc_req=1, mem_addr=RESET_PC.
- Issue: one request per cycle max; sustained one per cycle when mem_rdy=1 and credits available.
- Response latency ≥1 cycle after accept; instr_valid rises the cycle after the mem_valid edge that pushes into empty buffer (no bypass).
- Redirect at cycle N: instr_valid=0 at N+1; proc_req=1 with mem_addr=redirect_pc at N+1 if drop < MAX_OUTST.
- Outputs instr/instr_pc read combinationally from FIFO head; stable while instr_valid && !instr_ready.
- rst asserted mid-transfer: all state cleared immediately; later mem_valid beats from prior requests ignored (outst=0).

## Test plan
- Reset release, mem_rdy=1, 1-cycle mem latency, instr_ready=1 -> addresses 0,4,8,… each cycle; instr_pc/instr stream in order, instr_valid first at reset+3.
- instr_ready=0 forever, DEPTH=4 -> exactly 4 requests accepted, proc_req then held 0, buffer holds PCs 0,4,8,12; raising instr_ready resumes at 16.
- mem_rdy=0 for 5 cycles -> proc_req held 1, mem_addr stable, pc unchanged, stall=1.
- 2 requests outstanding (0x0,0x4), redirect to 0x100 -> both responses discarded, next instr_pc=0x100, drop returns to 0.
- Redirect coincident with mem_valid and instr_ready -> response dropped, no pop effect, drop = outst-1, buffer empty next cycle.
- pc=0xFFFFFFFC issue -> next mem_addr=0x00000000.
